stoch_decode_mat: RTL and testbench
===================================

# stoch_decode_mat

Matrix of stochastic-to-binary decoders: each element counts the ones in its unipolar stochastic bitstream over a fixed window of 2^WINDOW_LOG2 enabled cycles and presents the count as an unsigned fixed-point estimate (value = count / 2^WINDOW_LOG2). It sits at the output end of stochastic datapaths, after the decorrelator and generator matrices, and converts bitstreams back to binary for readout or host transfer. All elements share one window counter and one valid/ready output handshake.

## Interface

- NUM_ROWS, 2, matrix rows
- NUM_COLS, 2, matrix columns
- WINDOW_LOG2, 8, log2 of window length in enabled cycles (≥1); count width CW = WINDOW_LOG2+1
- CLK  input  1  clock, all state updates on rising edge
- nRST  input  1  reset, asynchronous, active-low
- en  input  1  A carries a valid bit this cycle
- clear  input  1  synchronous window restart
- A  input  [NUM_ROWS-1:0][NUM_COLS-1:0]  stochastic bit per element
- Y  output  [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0]  latched count per element
- y_valid  output  1  Y holds an unconsumed result
- y_ready  input  1  consumer accepts Y
- overrun  output  1  sticky: a result was overwritten before acceptance

## Operation

- Internal state: window counter wcnt (WINDOW_LOG2 bits), per-element accumulator acc[i][j] (CW bits), output registers Y, y_valid, overrun.
- Accumulate: on edge with en=1, clear=0: acc[i][j] += A[i][j]; wcnt += 1 (wraps).
- Window end: edge with en=1, clear=0, wcnt = 2^WINDOW_LOG2−1: Y[i][j] ← acc[i][j] + A[i][j]; all acc ← 0; wcnt ← 0; y_valid ← 1. Final bit is included, so all-ones window gives Y = 2^WINDOW_LOG2 (no overflow; CW bits sized for this).
- en=0: acc, wcnt hold; window length counts enabled cycles only.
- Handshake: transfer occurs on an edge where y_valid=1 and y_ready=1; y_valid ← 0 unless a window end occurs on the same edge. y_ready while y_valid=0 has no effect.
- Simultaneous window end and transfer: new Y loaded, y_valid stays 1, overrun unchanged.
- Window end while y_valid=1 and y_ready=0: Y overwritten with new result, y_valid stays 1, overrun ← 1 (sticky).
- clear=1 (priority over en and handshake): acc ← 0, wcnt ← 0, Y ← 0, y_valid ← 0, overrun ← 0. The in-progress window is discarded; A ignored that cycle.
- Arithmetic: unsigned, no saturation needed; acc never exceeds 2^WINDOW_LOG2.

## Timing

- Reset (nRST=0, async): wcnt=0, acc=0, Y=0, y_valid=0, overrun=0; holds while low. Reset mid-window discards partial counts; the first window after release starts at wcnt=0.
- Latency: Y and y_valid update on the same edge that samples the last bit of the window; visible in the following cycle.
- Throughput: one result per 2^WINDOW_LOG2 enabled cycles; with en held high, consecutive results exactly 2^WINDOW_LOG2 cycles apart, no dead cycles between windows.
- Y stable while y_valid=1 and no window end occurs.
- Outputs registered; no combinational path from A, en or y_ready to any output.

## Test plan

- WINDOW_LOG2=3, 2x2; en=1, A all ones for 8 cycles, y_ready=1 → after 8th edge Y=8 for all elements, y_valid=1 for one cycle, overrun=0.
- A[0][0]=alternating 1/0, A[0][1]=0, A[1][0]=1 on first cycle only, A[1][1]=1 → Y = {4, 0, 1, 8}.
- en toggled every other cycle, A all ones → result appears after 8 enabled (16 total) cycles, Y=8; bits during en=0 not counted.
- y_ready=0 across two full windows (first A all ones, second all zeros) → after second window Y=0, y_valid=1, overrun=1; raise y_ready → y_valid drops next edge, overrun stays 1 until clear.
- clear asserted after 5 enabled cycles of ones → no result emitted; next 8 enabled cycles of ones give Y=8; overrun, y_valid cleared by clear.
- nRST pulsed low mid-window (wcnt=4) → all outputs 0 immediately (asynchronously); following full window of ones gives Y=8 exactly 8 enabled cycles after release.

Source files
------------

// File: rtl/stoch_decode_mat.sv
// Matrix of stochastic-to-binary decoders. Each element counts ones over a shared
// window of 2^WINDOW_LOG2 enabled cycles and latches the count behind one valid/ready port.

module stoch_decode_cell #(
    parameter int CW = 9
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          clear,
    input  logic          en,
    input  logic          win_end,
    input  logic          a,
    output logic [CW-1:0] y
);
    logic [CW-1:0] acc;
    logic [CW-1:0] sum;

    // The final bit of a window is folded in on the same edge that latches y.
    assign sum = acc + CW'(a);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc <= '0;
            y   <= '0;
        end else if (clear) begin
            acc <= '0;
            y   <= '0;
        end else if (en) begin
            if (win_end) begin
                y   <= sum;
                acc <= '0;
            end else begin
                acc <= sum;
            end
        end
    end
endmodule

module stoch_decode_mat #(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int WINDOW_LOG2 = 8,
    localparam int CW         = WINDOW_LOG2 + 1
) (
    input  logic                                     CLK,
    input  logic                                     nRST,
    input  logic                                     en,
    input  logic                                     clear,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]        A,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0] Y,
    output logic                                     y_valid,
    input  logic                                     y_ready,
    output logic                                     overrun
);
    logic [WINDOW_LOG2-1:0] wcnt;
    logic                   win_end;

    assign win_end = en && !clear && (wcnt == '1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wcnt    <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (clear) begin
            wcnt    <= '0;
            y_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (en)
                wcnt <= wcnt + WINDOW_LOG2'(1);
            if (win_end) begin
                // A fresh result landing on an unaccepted one is flagged, never dropped silently.
                y_valid <= 1'b1;
                if (y_valid && !y_ready)
                    overrun <= 1'b1;
            end else if (y_valid && y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
        for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
            stoch_decode_cell #(.CW(CW)) u_cell (
                .CLK     (CLK),
                .nRST    (nRST),
                .clear   (clear),
                .en      (en),
                .win_end (win_end),
                .a       (A[i][j]),
                .y       (Y[i][j])
            );
        end
    end
endmodule

// File: tb/tb_stoch_decode_mat.sv
// Bench for stoch_decode_mat (2x2, 8-cycle window): table vectors, directed
// corner sequences and random traffic against a window-queue reference model.

module tb_stoch_decode_mat;
    logic                 CLK;
    logic                 nRST;
    logic                 en;
    logic                 clear;
    logic [1:0][1:0]      A;
    logic [1:0][1:0][3:0] Y;
    logic                 y_valid;
    logic                 y_ready;
    logic                 overrun;

    stoch_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_LOG2(3)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .en      (en),
        .clear   (clear),
        .A       (A),
        .Y       (Y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .overrun (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [15:0] yf;
    assign yf = Y;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: the current window is a queue of sampled A vectors.
    logic [3:0]  win_q[$];
    logic [15:0] m_y;
    logic        m_valid;
    logic        m_ovr;

    typedef struct {
        logic        e;
        logic [3:0]  a;
        logic        r;
        logic [15:0] ey;
        logic        ev;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        win_q.delete();
        m_y = '0; m_valid = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic c, input logic r, input logic [3:0] a);
        logic endw;
        int   cnt;
        endw = 1'b0;
        if (c) begin
            model_reset();
        end else begin
            if (e) begin
                win_q.push_back(a);
                if (win_q.size() == 8) endw = 1'b1;
            end
            if (endw) begin
                for (int k = 0; k < 4; k++) begin
                    cnt = 0;
                    foreach (win_q[n]) cnt += int'(win_q[n][k]);
                    m_y[k*4 +: 4] = 4'(cnt);
                end
                win_q.delete();
                if (m_valid && !r) m_ovr = 1'b1;
                m_valid = 1'b1;
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Drive one cycle, advance the model, sample #1 after the edge and compare.
    task automatic cyc(input logic e, input logic c, input logic r, input logic [3:0] a);
        en = e; clear = c; y_ready = r; A = a;
        model_step(e, c, r, a);
        @(posedge CLK); #1;
        check("model_y",       {16'h0, yf}, {16'h0, m_y});
        check("model_y_valid", {31'h0, y_valid}, {31'h0, m_valid});
        check("model_overrun", {31'h0, overrun}, {31'h0, m_ovr});
    endtask

    initial begin
        int first_v;

        for (int k = 0; k < 8; k++) begin
            tbl[k].e  = 1'b1;
            tbl[k].r  = 1'b1;
            tbl[k].a  = {1'b1, (k == 0), 1'b0, (k % 2 == 0)};
            tbl[k].ey = (k == 7) ? 16'h8104 : 16'h0000;
            tbl[k].ev = (k == 7);
        end

        nRST = 1'b0; en = 1'b0; clear = 1'b0; y_ready = 1'b0; A = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_y", {16'h0, yf}, 32'h0);
        check("reset_valid", {31'h0, y_valid}, 32'h0);
        check("reset_overrun", {31'h0, overrun}, 32'h0);
        @(negedge CLK); nRST = 1'b1;
        @(posedge CLK); #1;

        // All ones, consumer always ready.
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 1'b1, 4'hF);
        check("ones_y", {16'h0, yf}, 32'h8888);
        check("ones_valid", {31'h0, y_valid}, 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 4'h0);
        check("ones_valid_one_cycle", {31'h0, y_valid}, 32'h0);
        check("ones_overrun", {31'h0, overrun}, 32'h0);

        // Table vectors: per-element patterns.
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            cyc(tbl[k].e, 1'b0, tbl[k].r, tbl[k].a);
            check("tbl_y", {16'h0, yf}, {16'h0, tbl[k].ey});
            check("tbl_valid", {31'h0, y_valid}, {31'h0, tbl[k].ev});
        end
        cyc(1'b0, 1'b0, 1'b1, 4'h0);

        // en every other cycle; A ones even while disabled.
        first_v = -1;
        for (int k = 0; k < 16; k++) begin
            cyc((k % 2 == 1), 1'b0, 1'b1, 4'hF);
            if (y_valid && first_v < 0) first_v = k + 1;
        end
        check("gated_latency", first_v, 16);
        check("gated_y", {16'h0, yf}, 32'h8888);
        cyc(1'b0, 1'b0, 1'b1, 4'h0);

        // Two windows unaccepted -> overrun.
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 1'b0, 4'hF);
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 1'b0, 4'h0);
        check("ovr_y", {16'h0, yf}, 32'h0);
        check("ovr_valid", {31'h0, y_valid}, 32'h1);
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 4'h0);
        check("ovr_valid_drop", {31'h0, y_valid}, 32'h0);
        check("ovr_sticky", {31'h0, overrun}, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        check("ovr_still_sticky", {31'h0, overrun}, 32'h1);

        // Clear mid-window discards the partial count.
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b1, 4'hF);
        cyc(1'b1, 1'b1, 1'b1, 4'hF);
        check("clr_overrun", {31'h0, overrun}, 32'h0);
        check("clr_valid", {31'h0, y_valid}, 32'h0);
        for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0, 1'b1, 4'hF);
        check("clr_no_early", {31'h0, y_valid}, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 4'hF);
        check("clr_y", {16'h0, yf}, 32'h8888);
        check("clr_valid_after", {31'h0, y_valid}, 32'h1);

        // Async reset at wcnt=4 with a pending result and overrun set.
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 1'b0, 4'hF);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0, 4'hA);
        check("pre_rst_overrun", {31'h0, overrun}, 32'h1);
        en = 1'b0; y_ready = 1'b0;
        #2 nRST = 1'b0;
        #1;
        model_reset();
        check("arst_y", {16'h0, yf}, 32'h0);
        check("arst_valid", {31'h0, y_valid}, 32'h0);
        check("arst_overrun", {31'h0, overrun}, 32'h0);
        @(negedge CLK); nRST = 1'b1;
        @(posedge CLK); #1;
        for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0, 1'b1, 4'hF);
        check("arst_no_early", {31'h0, y_valid}, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 4'hF);
        check("arst_y_after", {16'h0, yf}, 32'h8888);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++)
            cyc(($urandom_range(9, 0) < 7), ($urandom_range(49, 0) == 0),
                ($urandom_range(1, 0) == 1), 4'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
